prog_freq_divider: RTL and testbench



---
 rtl/prog_freq_divider_pkg.sv | 23 ++
 rtl/prog_freq_divider.sv | 154 +++++++++++++++
 tb/tb_prog_freq_divider.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_freq_divider_pkg.sv
// ---------------------------------------------------------------------------
// prog_freq_divider_pkg
// Shared definitions for the programmable frequency divider:
//   - state_t : FSM state encoding (IDLE / LOW / HIGH, 2 bits)
//   - MIN_DIV : smallest legal divisor
//   - lo_len  : length of the low phase for divisor n (ceil(n/2))
// ---------------------------------------------------------------------------
package prog_freq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  // The low phase takes the odd cycle, so odd divisors run slightly low-heavy.
  function automatic int unsigned lo_len(input int unsigned n);
    return n - (n / 2);
  endfunction

endpackage

// File: rtl/prog_freq_divider.sv
// ---------------------------------------------------------------------------
// prog_freq_divider
// Runtime-programmable divider. Produces a registered clk_out whose period is
// exactly cur_div input cycles (low ceil(N/2), high floor(N/2)), plus a
// one-cycle tick coincident with every clk_out rising edge for use as a
// clock enable on clk.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   en       in   run request, sampled in IDLE and at period end only
//   load     in   one-cycle strobe capturing div_val
//   div_val  in   requested divisor N (WIDTH bits, legal 2..2^WIDTH-1)
//   clk_out  out  divided output, registered
//   tick     out  one-cycle pulse with each clk_out rise
//   busy     out  high while a period is in progress
//   div_err  out  one-cycle pulse after a load with div_val < 2
// ---------------------------------------------------------------------------
module prog_freq_divider
  import prog_freq_divider_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] cur_div, cur_div_nxt;
  logic [WIDTH-1:0] pend_div, pend_div_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic             clk_out_nxt, tick_nxt, div_err_nxt;

  logic [WIDTH-1:0] lo_last, hi_last;
  logic             load_ok;

  // Terminal counts of each phase. cur_div only changes at a period boundary
  // or in IDLE, so these are stable for the whole period in progress.
  assign lo_last = WIDTH'(lo_len(32'(cur_div)) - 32'd1);
  assign hi_last = (cur_div >> 1) - ONE;
  assign load_ok = load && (div_val >= MIN_DIV_W);

  assign busy = (state != IDLE);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cur_div_nxt    = cur_div;
    pend_div_nxt   = pend_div;
    pend_valid_nxt = pend_valid;
    clk_out_nxt    = clk_out;
    tick_nxt       = 1'b0;
    div_err_nxt    = load && !load_ok;

    case (state)
      IDLE: begin
        clk_out_nxt = 1'b0;
        cnt_nxt     = '0;
        // A divisor pended during the last period takes effect before the
        // next one starts; a fresh load in this same cycle is newer and wins.
        if (pend_valid) begin
          cur_div_nxt    = pend_div;
          pend_valid_nxt = 1'b0;
        end
        if (load_ok) begin
          cur_div_nxt    = div_val;
          pend_valid_nxt = 1'b0;
        end
        if (en) state_nxt = LOW;
      end

      LOW: begin
        if (cnt == lo_last) begin
          state_nxt   = HIGH;
          cnt_nxt     = '0;
          clk_out_nxt = 1'b1;
          tick_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end

      HIGH: begin
        if (cnt == hi_last) begin
          // Period end: the only running point where the ratio may change
          // or the divider may stop, so clk_out never produces a runt.
          if (pend_valid) begin
            cur_div_nxt    = pend_div;
            pend_valid_nxt = 1'b0;
          end
          cnt_nxt     = '0;
          clk_out_nxt = 1'b0;
          state_nxt   = en ? LOW : IDLE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end

      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        clk_out_nxt = 1'b0;
      end
    endcase

    // While running, a good load is only shadowed. Placed last so a load on
    // the period-end edge is kept for the following period end.
    if (load_ok && (state != IDLE)) begin
      pend_div_nxt   = div_val;
      pend_valid_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_div    <= WIDTH'(DEFAULT_DIV);
      // NOTE: pend_div is a plain data register gated by pend_valid; it is
      // reset anyway so the design never carries X into simulation.
      pend_div   <= WIDTH'(DEFAULT_DIV);
      pend_valid <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      div_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur_div    <= cur_div_nxt;
      pend_div   <= pend_div_nxt;
      pend_valid <= pend_valid_nxt;
      clk_out    <= clk_out_nxt;
      tick       <= tick_nxt;
      div_err    <= div_err_nxt;
    end
  end

endmodule

// File: tb/tb_prog_freq_divider.sv
// ---------------------------------------------------------------------------
// tb_prog_freq_divider
// Self-checking bench: a period/position model of the divider is compared
// against the DUT on every falling edge, and directed scenarios pin the
// model with hand-computed waveforms.
// ---------------------------------------------------------------------------
module tb_prog_freq_divider;

  localparam int W   = 8;
  localparam int DEF = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] div_val;
  logic         clk_out;
  logic         tick;
  logic         busy;
  logic         div_err;

  int checks   = 0;
  int failures = 0;

  prog_freq_divider #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .load    (load),
    .div_val (div_val),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy),
    .div_err (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Running divider is a position 0..N-1 within the current period; the
  // output is high for positions at or beyond ceil(N/2).
  int unsigned m_n, m_pend_n, m_pos;
  bit          m_run, m_pend, m_err, m_valid, m_ok;

  function automatic int unsigned lo_of(input int unsigned n);
    return (n + 1) / 2;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_n = DEF; m_pend = 0; m_err = 0; m_valid = 1;
    end else begin
      m_ok  = load && (div_val >= 2);
      m_err = load && (div_val < 2);
      if (!m_run) begin
        if (m_pend) m_n = m_pend_n;
        m_pend = 0;
        if (m_ok) m_n = div_val;
        if (en) begin m_run = 1; m_pos = 0; end
      end else begin
        if (m_pos == m_n - 1) begin
          if (m_pend) begin m_n = m_pend_n; m_pend = 0; end
          if (!en) m_run = 0;
          m_pos = 0;
        end else begin
          m_pos++;
        end
        if (m_ok) begin m_pend = 1; m_pend_n = div_val; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_clk_out", 32'(clk_out), 32'(m_run && (m_pos >= lo_of(m_n))));
      check("model_tick",    32'(tick),    32'(m_run && (m_pos == lo_of(m_n))));
      check("model_busy",    32'(busy),    32'(m_run));
      check("model_div_err", 32'(div_err), 32'(m_err));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; div_val = '0;
    repeat (2) @(negedge clk);
    check("reset_clk_out", 32'(clk_out), 32'd0);
    check("reset_busy",    32'(busy),    32'd0);
    check("reset_tick",    32'(tick),    32'd0);
    check("reset_div_err", 32'(div_err), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic capture(input int n, output logic [31:0] bits, output int ticks);
    bits  = '0;
    ticks = 0;
    repeat (n) begin
      @(negedge clk);
      bits = {bits[30:0], clk_out};
      if (tick) ticks++;
    end
  endtask

  task automatic idle_load(input logic [W-1:0] v);
    load = 1'b1; div_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [31:0] bits;
  int          nt;
  int          k;

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; div_val = '0;
    @(negedge clk);

    // 1: default divisor 4 -> 0,0,1,1 repeating
    do_reset();
    en = 1'b1;
    capture(8, bits, nt);
    check("div4_pattern", bits, 32'b00110011);
    check("div4_ticks", 32'(nt), 32'd2);
    check("div4_busy", 32'(busy), 32'd1);

    // 2: load 5 in IDLE -> low 3 / high 2
    do_reset();
    idle_load(8'd5);
    en = 1'b1;
    capture(10, bits, nt);
    check("div5_pattern", bits, 32'b0001100011);
    check("div5_ticks", 32'(nt), 32'd2);

    // 3: running N=4, load 3 in LOW -> current period finishes, then 3s
    do_reset();
    en = 1'b1;
    @(negedge clk);
    idle_load(8'd3);
    capture(9, bits, nt);
    check("div4_to_3_pattern", bits, 32'b110010010);

    // 4: illegal loads flag div_err and leave the ratio alone
    do_reset();
    en = 1'b1;
    repeat (3) @(negedge clk);
    idle_load(8'd0);
    check("err0_pulse", 32'(div_err), 32'd1);
    @(negedge clk);
    check("err0_clear", 32'(div_err), 32'd0);
    idle_load(8'd1);
    check("err1_pulse", 32'(div_err), 32'd1);
    capture(12, bits, nt);
    check("err_period_kept", 32'(nt), 32'd3);

    // 5: N=6, en dropped in first HIGH cycle -> period completes, then IDLE
    do_reset();
    idle_load(8'd6);
    en = 1'b1;
    k = 0;
    while (!tick && k < 40) begin @(negedge clk); k++; end
    check("div6_tick_seen", 32'(tick), 32'd1);
    en = 1'b0;
    capture(4, bits, nt);
    check("stop_pattern", bits[3:0], 32'b1100);
    check("stop_ticks", 32'(nt), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);

    // 6: reset while high with N=255 -> clk_out drops, divisor back to 4
    do_reset();
    idle_load(8'd255);
    en = 1'b1;
    k = 0;
    while (!clk_out && k < 300) begin @(negedge clk); k++; end
    check("div255_high_seen", 32'(clk_out), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_clk_out", 32'(clk_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    capture(8, bits, nt);
    check("abort_default_div", bits, 32'b00110011);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n   = ($urandom_range(0, 499) != 0);
      en      = ($urandom_range(0, 9) != 0);
      load    = ($urandom_range(0, 11) == 0);
      div_val = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                            : W'($urandom_range(0, 9));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
